trigger_capture: RTL

Pre-trigger capture controller for the wavetrace sample path. It drives an external `shift_ram` delay line, watches the live sample stream for a threshold crossing, and then emits a fixed-length window of delayed samples. Every window therefore contains `PreDepth` samples from before the trigger. The block sits between the sample source and the trace buffer/display writer, and consumes the `shift_ram` output directly.

---
 rtl/trigger_capture.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/trigger_capture.sv
// trigger_capture: pre-trigger capture controller in front of an external
// shift_ram delay line. Waits for a rising threshold crossing on the live
// stream, then emits CaptureLen delayed samples, PreDepth of which precede
// the trigger sample.
// Optional feature macro: TRIGGER_CAPTURE_AUTO_REARM_EN (continuous capture).
module trigger_capture #(
  parameter int Width      = 8,
  parameter int PreDepth   = 32,
  parameter int CaptureLen = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [Width-1:0] din_data,
  input  logic             din_valid,
  input  logic [Width-1:0] threshold,
  input  logic             arm,
  output logic             shift_en,
  output logic [Width-1:0] shift_din,
  input  logic [Width-1:0] shift_dout,
  output logic [Width-1:0] dout_data,
  output logic             dout_valid,
  output logic             dout_last,
  output logic             busy,
  output logic             trig_pulse
);

  localparam int FillW = $clog2(PreDepth + 1);
  localparam int CapW  = $clog2(CaptureLen);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    ARMED,
    CAPTURE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [Width-1:0] thr_q;
  logic [Width-1:0] prev_q;
  logic [FillW-1:0] fill_cnt;
  logic [CapW-1:0]  cap_cnt;

  // Pipeline stage aligned with the registered shift_ram read
  logic cap_q;
  logic last_q;

  logic fill_done;
  logic trig_hit;
  logic cap_last;
  logic cap_accept;
  logic last_accept;
  logic trig_fire;

  // The delay line advances on every valid sample regardless of state
  assign shift_en  = din_valid;
  assign shift_din = din_data;

  assign fill_done = din_valid && (fill_cnt == FillW'(PreDepth - 1));
  assign trig_hit  = din_valid && (prev_q < thr_q) && (din_data >= thr_q);
  assign cap_last  = din_valid && (cap_cnt == CapW'(CaptureLen - 1));

  // State register; reset wins over everything else
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state selection from arm, fill progress, trigger and window end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (arm) state_d = FILL;
      FILL:    if (fill_done) state_d = ARMED;
      ARMED:   if (trig_hit) state_d = CAPTURE;
      CAPTURE: begin
        if (cap_last) begin
`ifdef TRIGGER_CAPTURE_AUTO_REARM_EN
          state_d = FILL;
`else
          state_d = IDLE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Per-state control strobes; the trigger sample itself is window index 0
  always_comb begin
    busy        = (state_q != IDLE);
    trig_fire   = (state_q == ARMED) && trig_hit;
    cap_accept  = din_valid && ((state_q == CAPTURE) || trig_fire);
    last_accept = (state_q == CAPTURE) && cap_last;
  end

  // Threshold, history, counters and the two-stage output pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      thr_q      <= '0;
      prev_q     <= '0;
      fill_cnt   <= '0;
      cap_cnt    <= '0;
      cap_q      <= 1'b0;
      last_q     <= 1'b0;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
      dout_data  <= '0;
      trig_pulse <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (arm) begin
            thr_q    <= threshold;
            fill_cnt <= '0;
          end
        end
        FILL: begin
          if (din_valid) begin
            fill_cnt <= fill_cnt + FillW'(1);
            prev_q   <= din_data;
          end
        end
        ARMED: begin
          if (din_valid) begin
            prev_q <= din_data;
            if (trig_hit) cap_cnt <= CapW'(1);
          end
        end
        CAPTURE: begin
          if (din_valid) begin
            if (cap_last) begin
              fill_cnt <= '0;
            end else begin
              cap_cnt <= cap_cnt + CapW'(1);
            end
          end
        end
        default: ;
      endcase

      cap_q      <= cap_accept;
      last_q     <= last_accept;
      dout_valid <= cap_q;
      dout_last  <= last_q;
      if (cap_q) dout_data <= shift_dout;
      trig_pulse <= trig_fire;
    end
  end

endmodule
